// File: rtl/full_adder_pkg.sv
// Shared types and constants for the full adder slice.
//   RST_S_DEFAULT / RST_COUT_DEFAULT : default reset values of the output register
//   fa_result_t                      : 2-bit {cout, s} result
//   pack_result()                    : builds an fa_result_t from its two bits
package full_adder_pkg;

    localparam logic RST_S_DEFAULT    = 1'b0;
    localparam logic RST_COUT_DEFAULT = 1'b0;

    typedef struct packed {
        logic cout;
        logic s;
    } fa_result_t;

    function automatic fa_result_t pack_result(input logic cout, input logic s);
        fa_result_t r;
        r.cout = cout;
        r.s    = s;
        return r;
    endfunction

endpackage

// File: rtl/half_adder.sv
// Half adder: one-bit sum and carry of two bits.
//   a, b  : addend bits
//   sum   : a XOR b
//   carry : a AND b
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/full_adder.sv
// Full adder built from two half adders, with an optional output register.
//   REG_OUT  : 0 = combinational outputs, 1 = registered outputs (1-cycle latency)
//   RST_S    : s value while rst is high (REG_OUT=1 only)
//   RST_COUT : cout value while rst is high (REG_OUT=1 only)
//   clk, rst : clock and async active-high reset, used only when REG_OUT=1
//   x, y     : addend bits
//   cin      : carry-in
//   s, cout  : sum and carry-out, {cout,s} = x + y + cin
module full_adder
    import full_adder_pkg::*;
#(
    parameter bit   REG_OUT  = 1'b0,
    parameter logic RST_S    = RST_S_DEFAULT,
    parameter logic RST_COUT = RST_COUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic       ha0_sum;
    logic       ha0_carry;
    logic       ha1_sum;
    logic       ha1_carry;
    fa_result_t res_c;

    // First stage adds the addends, second stage folds in the carry-in.
    half_adder u_ha0 (
        .a     (x),
        .b     (y),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    half_adder u_ha1 (
        .a     (ha0_sum),
        .b     (cin),
        .sum   (ha1_sum),
        .carry (ha1_carry)
    );

    // The two carries can never both be set, so OR gives the majority function.
    assign res_c = pack_result(ha0_carry | ha1_carry, ha1_sum);

    generate
        if (REG_OUT) begin : g_reg
            fa_result_t res_q;

            // Output register; reset forces the configured values immediately.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= pack_result(RST_COUT, RST_S);
                end else begin
                    res_q <= res_c;
                end
            end

            assign s    = res_q.s;
            assign cout = res_q.cout;
        end else begin : g_comb
            // clk, rst and reset values have no role in the combinational build.
            logic unused_cfg;
            assign unused_cfg = ^{clk, rst, RST_S, RST_COUT};

            assign s    = res_c.s;
            assign cout = res_c.cout;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

    logic clk = 1'b0;
    logic rst;
    logic x, y, cin;
    logic nc_clk, nc_rst;
    logic s_c, cout_c;
    logic s_r, cout_r;
    logic s_r1, cout_r1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    full_adder #(.REG_OUT(1'b0)) u_comb (
        .clk (nc_clk), .rst (nc_rst),
        .x (x), .y (y), .cin (cin),
        .s (s_c), .cout (cout_c)
    );

    full_adder #(.REG_OUT(1'b1)) u_reg (
        .clk (clk), .rst (rst),
        .x (x), .y (y), .cin (cin),
        .s (s_r), .cout (cout_r)
    );

    full_adder #(.REG_OUT(1'b1), .RST_S(1'b1), .RST_COUT(1'b1)) u_reg1 (
        .clk (clk), .rst (rst),
        .x (x), .y (y), .cin (cin),
        .s (s_r1), .cout (cout_r1)
    );

    // Reference: arithmetic sum of three bits as a 2-bit number.
    function automatic logic [1:0] ref_sum(input logic a, input logic b, input logic c);
        int t;
        t = int'(a) + int'(b) + int'(c);
        return 2'(t);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        {x, y, cin} = 3'b000;
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b00) begin
            nerr++;
            $display("FAIL reset_default: got %b expected %b", {cout_r, s_r}, 2'b00);
        end
        nvec++;
        if ({cout_r1, s_r1} !== 2'b11) begin
            nerr++;
            $display("FAIL reset_ones_no_clock: got %b expected %b", {cout_r1, s_r1}, 2'b11);
        end
    endtask

    task automatic test_comb_sweep();
        logic [2:0] pat [8];
        logic [1:0] tab [8];
        pat = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
        tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            {x, y, cin} = pat[i];
            #1;
            nvec++;
            if ({cout_c, s_c} !== tab[i]) begin
                nerr++;
                $display("FAIL comb_sweep[%0d] in=%b: got %b expected %b", i, pat[i], {cout_c, s_c}, tab[i]);
            end
            nvec++;
            if ({cout_c, s_c} !== ref_sum(x, y, cin)) begin
                nerr++;
                $display("FAIL comb_model[%0d]: got %b expected %b", i, {cout_c, s_c}, ref_sum(x, y, cin));
            end
            // rst still high: registered outputs must ignore clock and inputs
            nvec++;
            if ({cout_r, s_r} !== 2'b00 || {cout_r1, s_r1} !== 2'b11) begin
                nerr++;
                $display("FAIL reset_hold[%0d]: got %b/%b expected 00/11", i, {cout_r, s_r}, {cout_r1, s_r1});
            end
            #9;
        end
    endtask

    task automatic test_comb_no_x();
        {x, y, cin} = 3'b111;
        #1;
        nvec++;
        if ({cout_c, s_c} !== 2'b11) begin
            nerr++;
            $display("FAIL comb_undriven_clk_rst: got %b expected %b", {cout_c, s_c}, 2'b11);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        rst = 1'b0;
        {x, y, cin} = 3'b111;
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b00) begin
            nerr++;
            $display("FAIL release_hold: got %b expected %b", {cout_r, s_r}, 2'b00);
        end
        @(posedge clk);
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b11 || {cout_r1, s_r1} !== 2'b11) begin
            nerr++;
            $display("FAIL first_edge_load: got %b/%b expected 11/11", {cout_r, s_r}, {cout_r1, s_r1});
        end
        @(negedge clk);
        {x, y, cin} = 3'b101;
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b11) begin
            nerr++;
            $display("FAIL hold_before_edge: got %b expected %b", {cout_r, s_r}, 2'b11);
        end
        {x, y, cin} = 3'b000;
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b11) begin
            nerr++;
            $display("FAIL midcycle_change: got %b expected %b", {cout_r, s_r}, 2'b11);
        end
        {x, y, cin} = 3'b101;
        @(posedge clk);
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b10) begin
            nerr++;
            $display("FAIL latency_101: got %b expected %b", {cout_r, s_r}, 2'b10);
        end
    endtask

    task automatic test_reset_pulse();
        @(negedge clk);
        {x, y, cin} = 3'b111;
        @(posedge clk);
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b11) begin
            nerr++;
            $display("FAIL pre_pulse: got %b expected %b", {cout_r, s_r}, 2'b11);
        end
        @(negedge clk);
        {x, y, cin} = 3'b010;
        #1;
        rst = 1'b1;
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b00 || {cout_r1, s_r1} !== 2'b11) begin
            nerr++;
            $display("FAIL async_reset: got %b/%b expected 00/11", {cout_r, s_r}, {cout_r1, s_r1});
        end
        @(posedge clk);
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b00) begin
            nerr++;
            $display("FAIL reset_over_edge: got %b expected %b", {cout_r, s_r}, 2'b00);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b00 || {cout_r1, s_r1} !== 2'b11) begin
            nerr++;
            $display("FAIL post_release_hold: got %b/%b expected 00/11", {cout_r, s_r}, {cout_r1, s_r1});
        end
        @(posedge clk);
        #1;
        nvec++;
        if ({cout_r, s_r} !== 2'b01 || {cout_r1, s_r1} !== 2'b01) begin
            nerr++;
            $display("FAIL post_release_load: got %b/%b expected 01/01", {cout_r, s_r}, {cout_r1, s_r1});
        end
    endtask

    task automatic test_random();
        logic [1:0] exp;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            x   = 1'($urandom);
            y   = 1'($urandom);
            cin = 1'($urandom);
            exp = ref_sum(x, y, cin);
            #1;
            nvec++;
            if ({cout_c, s_c} !== exp) begin
                nerr++;
                $display("FAIL rand_comb[%0d]: got %b expected %b", i, {cout_c, s_c}, exp);
            end
            @(posedge clk);
            #1;
            nvec++;
            if ({cout_r, s_r} !== exp || {cout_r1, s_r1} !== exp) begin
                nerr++;
                $display("FAIL rand_reg[%0d]: got %b/%b expected %b", i, {cout_r, s_r}, {cout_r1, s_r1}, exp);
            end
        end
    endtask

    initial begin
        nc_clk = 1'bx;
        nc_rst = 1'bx;
        test_reset();
        test_comb_sweep();
        test_comb_no_x();
        test_latency();
        test_reset_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter REG_OUT, default 0: 0 = sum/carry outputs combinational; 1 = sum/carry outputs registered, one-cycle latency.
REQ-002 Parameter RST_S, default 1'b0: value loaded into s on reset when REG_OUT=1.
REQ-003 Parameter RST_COUT, default 1'b0: value loaded into cout on reset when REG_OUT=1.
REQ-004 clk  input  1  single clock, rising-edge; used only when REG_OUT=1.
REQ-005 rst  input  1  reset, asynchronous, active-high; used only when REG_OUT=1.
REQ-006 x  input  1  addend bit A.
REQ-007 y  input  1  addend bit B.
REQ-008 cin  input  1  carry-in bit.
REQ-009 s  output  1  sum bit.
REQ-010 cout  output  1  carry-out bit.

Function
REQ-011 The block SHALL compute s = x XOR y XOR cin.
REQ-012 The block SHALL compute cout = (x AND y) OR (cin AND (x XOR y)), i.e. majority of x, y, cin.
REQ-013 {cout,s} SHALL equal the 2-bit unsigned sum x+y+cin for all 8 input combinations; no overflow is possible.
REQ-014 With REG_OUT=0, s and cout SHALL follow inputs with zero cycle latency, purely combinational, no latches, independent of clk and rst.
REQ-015 With REG_OUT=0, clk and rst SHALL be ignored; leaving them undriven (X/Z) SHALL NOT affect s or cout.
REQ-016 With REG_OUT=1, s and cout SHALL update on each rising clk edge to the function of x, y, cin sampled at that edge (latency exactly 1 cycle, throughput 1 per cycle).
REQ-017 With REG_OUT=1, s and cout SHALL be glitch-free between clock edges.
REQ-018 The block SHALL have no handshake, no state machine, and no internal state other than the optional output register.
REQ-019 Input changes between clock edges with REG_OUT=1 SHALL have no effect until the next rising edge.

Reset
REQ-020 With REG_OUT=1, asserting rst SHALL immediately (asynchronously, no clock needed) force s=RST_S and cout=RST_COUT.
REQ-021 While rst is high, the registered outputs SHALL hold reset values regardless of clk and inputs.
REQ-022 After rst deasserts, the first rising clk edge SHALL load the function of the then-current inputs.
REQ-023 Reset asserted mid-operation SHALL discard the in-flight registered result; no result SHALL reappear after release.
REQ-024 With REG_OUT=0, no reset behaviour SHALL exist.

Structure
REQ-025 A shared package full_adder_pkg SHALL hold the reset-value constants (default 1'b0) and a 2-bit typedef for the {cout,s} result.
REQ-026 The combinational core SHALL be built from one sub-module, half_adder (inputs a,b; outputs sum=a XOR b, carry=a AND b), instantiated twice with an OR merging the carries.
REQ-027 The output register SHALL be a generate-selected block keyed on REG_OUT; no other sequential logic is permitted.

Verification
REQ-028 REG_OUT=0, sweep {x,y,cin} through 000,010,100,110,001,011,101,111 at 10 ns steps -> {cout,s} = 00,01,01,10,01,10,10,11 respectively, within the same timestep.
REQ-029 REG_OUT=0, clk and rst left undriven, x=1,y=1,cin=1 -> s=1, cout=1 (no X propagation).
REQ-030 REG_OUT=1, apply x=1,y=0,cin=1 before edge N -> s=0,cout=1 visible only after edge N, previous value held before it.
REQ-031 REG_OUT=1, outputs at 1,1, pulse rst high between clock edges -> s=0,cout=0 immediately, held until first edge after release.
REQ-032 REG_OUT=1, RST_S=1,RST_COUT=1, assert rst -> s=1,cout=1 without a clock edge.
REQ-033 REG_OUT=1, randomized inputs each cycle for 1000 cycles -> {cout,s} equals x+y+cin of the previous cycle at every edge.
